// File: rtl/texture_bank_memory.sv
// texture_bank_memory: banked on-chip texture store.
// The bus side writes 32-bit words into a tile. The rasteriser reads one
// whole tile per request, and the response arrives two cycles after the
// request. The block tracks a valid bit for each tile, reports hit or
// miss for each read, supports a bulk invalidate, and flags writes whose
// address is out of range.
// Optional build macro: TEXMEM_BYTE_SWAP_EN. When it is defined, each
// stored word is byte-reversed from bus order into texel order.
module texture_bank_memory #(
  parameter int unsigned TILE_BYTES = 256,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned TILE_COUNT = 128,
  parameter logic [26:0] BASE_ADDR  = 27'h0002000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   i_wdata,
  input  logic                          i_wea,
  input  logic [26:0]                   i_waddr,
  output logic                          o_werr,
  input  logic                          i_inval,
  input  logic                          i_rreq,
  input  logic [$clog2(TILE_COUNT)-1:0] i_rtile,
  output logic                          o_rvalid,
  output logic                          o_rhit,
  output logic [TILE_BYTES*8-1:0]       o_rdata,
  output logic [$clog2(TILE_COUNT):0]   o_valid_cnt
);

  localparam int unsigned WPT  = TILE_BYTES / 4;
  localparam int unsigned WPB  = WPT / NUM_BANKS;
  localparam int unsigned TW   = $clog2(TILE_COUNT);
  localparam int unsigned TBL  = $clog2(TILE_BYTES);
  localparam int unsigned WW   = TBL - 2;
  localparam int unsigned BKW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned RW   = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned RDW  = TILE_BYTES * 8;
  localparam logic [27:0] SPAN = 28'(TILE_COUNT * TILE_BYTES);

  logic [26:0]     off;
  logic            in_range;
  logic            wr_ok;
  logic [TW-1:0]   w_tile;
  logic [WW-1:0]   w_word;
  logic [BKW-1:0]  w_bank;
  logic [RW-1:0]   w_row;
  logic [31:0]     w_data;
  logic [RDW-1:0]  rd_word;

  logic [TILE_COUNT-1:0] valid_q, valid_d;
  logic [TW:0]           cnt_q, cnt_d;
  logic                  werr_q;
  logic                  s1_vld_q, s1_hit_q;
  logic                  rvalid_q, rhit_q;
  logic [RDW-1:0]        rdata_q;

  // Decode the write address into tile, word, bank and bank row.
  // Address bits [1:0] are ignored.
  always_comb begin
    off      = i_waddr - BASE_ADDR;
    in_range = (i_waddr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    wr_ok    = i_wea && in_range;
    w_tile   = off[TBL +: TW];
    w_word   = off[2 +: WW];
    w_bank   = BKW'(32'(w_word) / WPB);
    w_row    = RW'(32'(w_word) % WPB);
  end

`ifdef TEXMEM_BYTE_SWAP_EN
  assign w_data = {i_wdata[7:0], i_wdata[15:8], i_wdata[23:16], i_wdata[31:24]};
`else
  assign w_data = i_wdata;
`endif

  // Each bank is a simple dual-port RAM. The write port takes one word;
  // the read port returns one full bank row. The read is registered in the
  // request cycle, so a write on the same edge is not seen (read-old).
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WPB-1:0][31:0] mem [TILE_COUNT];
    logic [WPB-1:0][31:0] rd_q;

    // Bank write port and registered read port.
    always_ff @(posedge clk) begin
      if (wr_ok && (w_bank == BKW'(b))) mem[w_tile][w_row] <= w_data;
      if (i_rreq) rd_q <= mem[i_rtile];
    end

    assign rd_word[b*WPB*32 +: WPB*32] = rd_q;
  end

  // Next state of the per-tile valid bits.
  // Invalidate is applied last, so it overrides a same-cycle write.
  always_comb begin
    valid_d = valid_q;
    if (wr_ok) begin
      if (w_word == WW'(WPT - 1))   valid_d[w_tile] = 1'b1;
      else if (w_word == '0)        valid_d[w_tile] = 1'b0;
    end
    if (i_inval) valid_d = '0;
  end

  // Popcount of the current valid bits. The result is registered, so the
  // count output lags the valid bits by one cycle.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < TILE_COUNT; i++) cnt_d = cnt_d + (TW+1)'(valid_q[i]);
  end

  // Valid bits, valid count and the out-of-range write pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      werr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      werr_q  <= i_wea && !in_range;
    end
  end

  // Two-stage read pipeline. The hit flag is captured when the request is
  // accepted. The response registers hold their values between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_hit_q <= 1'b0;
      rvalid_q <= 1'b0;
      rhit_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      s1_vld_q <= i_rreq;
      s1_hit_q <= valid_q[i_rtile];
      rvalid_q <= s1_vld_q;
      if (s1_vld_q) begin
        rhit_q  <= s1_hit_q;
        rdata_q <= rd_word;
      end
    end
  end

  assign o_werr      = werr_q;
  assign o_rvalid    = rvalid_q;
  assign o_rhit      = rhit_q;
  assign o_rdata     = rdata_q;
  assign o_valid_cnt = cnt_q;

endmodule
